// File: rtl/ltc2311_pkg.sv
// Shared types and default constants for the LTC2311 capture front end.
// Holds the capture FSM state encoding and the frame-length helper.
package ltc2311_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StConvert,
      StWaitConv,
      StShift,
      StPush
   } state_e;

   localparam int unsigned DefDataWidth          = 16;
   localparam int unsigned DefSckHalfPeriod      = 2;
   localparam int unsigned DefCnvHighCycles      = 4;
   localparam int unsigned DefConvWaitCycles     = 45;
   localparam int unsigned DefSamplePeriodCycles = 128;

   // Cycles from the conversion-start edge up to and including the push cycle.
   function automatic int unsigned frame_cycles(input int unsigned data_width,
                                                input int unsigned sck_half_period,
                                                input int unsigned cnv_high_cycles,
                                                input int unsigned conv_wait_cycles);
      return cnv_high_cycles + conv_wait_cycles + 2 * sck_half_period * data_width + 1;
   endfunction

endpackage

// File: rtl/ltc2311_sck_divider.sv
// Serial clock generator for the LTC2311 read-out: low half first, then high half,
// flagging the edge that raises SCK (sample point) and the end of the final bit.
module ltc2311_sck_divider
   import ltc2311_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DefDataWidth,
   parameter int unsigned SCK_HALF_PERIOD = DefSckHalfPeriod
) (
   input  logic clock,
   input  logic reset,
   input  logic active,
   output logic sck,
   output logic sample,
   output logic last
);

   localparam int unsigned HalfWidth = (SCK_HALF_PERIOD > 1) ? $clog2(SCK_HALF_PERIOD) : 1;
   localparam int unsigned BitWidth  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [HalfWidth-1:0] HalfLast = HalfWidth'(SCK_HALF_PERIOD - 1);
   localparam logic [BitWidth-1:0]  BitLast  = BitWidth'(DATA_WIDTH - 1);

   logic [HalfWidth-1:0] half_q;
   logic [BitWidth-1:0]  bit_q;
   logic                 sck_q;
   logic                 half_end;

   assign half_end = active && (half_q == HalfLast);
   assign sample   = half_end && !sck_q;
   assign last     = half_end && sck_q && (bit_q == BitLast);
   assign sck      = sck_q;

   // Counters sit at zero whenever no shift is in progress, so every frame starts clean.
   always_ff @(posedge clock) begin
      if (reset || !active) begin
         half_q <= '0;
         bit_q  <= '0;
         sck_q  <= 1'b0;
      end else if (half_end) begin
         half_q <= '0;
         sck_q  <= !sck_q;
         if (sck_q) begin
            bit_q <= bit_q + BitWidth'(1);
         end
      end else begin
         half_q <= half_q + HalfWidth'(1);
      end
   end

endmodule

// File: rtl/ltc2311_capture.sv
// LTC2311 capture engine: periodic conversion start, serial read-out of one word
// and a single-cycle push into a downstream synchronous FIFO.
module ltc2311_capture
   import ltc2311_pkg::*;
#(
   parameter int unsigned DATA_WIDTH           = DefDataWidth,
   parameter int unsigned SCK_HALF_PERIOD      = DefSckHalfPeriod,
   parameter int unsigned CNV_HIGH_CYCLES      = DefCnvHighCycles,
   parameter int unsigned CONV_WAIT_CYCLES     = DefConvWaitCycles,
   parameter int unsigned SAMPLE_PERIOD_CYCLES = DefSamplePeriodCycles
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  adc_sdo,
   output logic                  adc_cnv,
   output logic                  adc_sck,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  write_increment,
   input  logic                  full,
   output logic [15:0]           overrun_count,
   output logic                  busy
);

   localparam int unsigned FrameCycles =
      frame_cycles(DATA_WIDTH, SCK_HALF_PERIOD, CNV_HIGH_CYCLES, CONV_WAIT_CYCLES);
   localparam int unsigned PeriodWidth =
      (SAMPLE_PERIOD_CYCLES > 1) ? $clog2(SAMPLE_PERIOD_CYCLES) : 1;
   localparam int unsigned TimerMax =
      (CNV_HIGH_CYCLES > CONV_WAIT_CYCLES) ? CNV_HIGH_CYCLES : CONV_WAIT_CYCLES;
   localparam int unsigned TimerWidth = (TimerMax > 1) ? $clog2(TimerMax) : 1;

   localparam logic [PeriodWidth-1:0] PeriodLast = PeriodWidth'(SAMPLE_PERIOD_CYCLES - 1);
   localparam logic [TimerWidth-1:0]  CnvLast    = TimerWidth'(CNV_HIGH_CYCLES - 1);
   localparam logic [TimerWidth-1:0]  WaitLast   = TimerWidth'(CONV_WAIT_CYCLES - 1);

   if (FrameCycles > SAMPLE_PERIOD_CYCLES) begin : g_frame_check
      $error("ltc2311_capture: frame of %0d cycles exceeds sample period of %0d",
             FrameCycles, SAMPLE_PERIOD_CYCLES);
   end
   if (SCK_HALF_PERIOD < 1 || CNV_HIGH_CYCLES < 1 || CONV_WAIT_CYCLES < 1
       || DATA_WIDTH < 2) begin : g_param_check
      $error("ltc2311_capture: timing parameters must be >= 1 and DATA_WIDTH >= 2");
   end

   state_e                  state_q;
   logic [PeriodWidth-1:0]  period_q;
   logic [TimerWidth-1:0]   timer_q;
   logic [DATA_WIDTH-1:0]   shift_q;
   logic [DATA_WIDTH-1:0]   write_data_q;
   logic [15:0]             overrun_q;
   logic                    adc_cnv_q;
   logic                    write_increment_q;
   logic                    busy_q;
   logic                    shift_active;
   logic                    sck_sample;
   logic                    sck_last;

   assign shift_active    = (state_q == StShift);
   assign adc_cnv         = adc_cnv_q;
   assign write_data      = write_data_q;
   assign write_increment = write_increment_q;
   assign overrun_count   = overrun_q;
   assign busy            = busy_q;

   ltc2311_sck_divider #(
      .DATA_WIDTH      (DATA_WIDTH),
      .SCK_HALF_PERIOD (SCK_HALF_PERIOD)
   ) u_sck_divider (
      .clock  (clock),
      .reset  (reset),
      .active (shift_active),
      .sck    (adc_sck),
      .sample (sck_sample),
      .last   (sck_last)
   );

   // Free-running sample-period timer; parked at zero while disabled so that
   // raising enable starts a conversion on the very next edge.
   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         period_q <= '0;
      end else if (period_q == PeriodLast) begin
         period_q <= '0;
      end else begin
         period_q <= period_q + PeriodWidth'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= StIdle;
         timer_q           <= '0;
         shift_q           <= '0;
         write_data_q      <= '0;
         overrun_q         <= '0;
         adc_cnv_q         <= 1'b0;
         write_increment_q <= 1'b0;
         busy_q            <= 1'b0;
      end else begin
         write_increment_q <= 1'b0;
         if (sck_sample) begin
            shift_q <= {shift_q[DATA_WIDTH-2:0], adc_sdo};
         end
         case (state_q)
            StIdle: begin
               if (enable && (period_q == '0)) begin
                  state_q   <= StConvert;
                  adc_cnv_q <= 1'b1;
                  busy_q    <= 1'b1;
                  timer_q   <= '0;
               end
            end
            StConvert: begin
               if (timer_q == CnvLast) begin
                  state_q   <= StWaitConv;
                  adc_cnv_q <= 1'b0;
                  timer_q   <= '0;
               end else begin
                  timer_q <= timer_q + TimerWidth'(1);
               end
            end
            StWaitConv: begin
               if (timer_q == WaitLast) begin
                  state_q <= StShift;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + TimerWidth'(1);
               end
            end
            StShift: begin
               if (sck_last) begin
                  state_q <= StPush;
               end
            end
            StPush: begin
               // A full FIFO drops the word and counts it instead of stalling the frame.
               if (!full) begin
                  write_increment_q <= 1'b1;
                  write_data_q      <= shift_q;
               end else if (overrun_q != 16'hFFFF) begin
                  overrun_q <= overrun_q + 16'd1;
               end
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q   <= StIdle;
               adc_cnv_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ltc2311_capture.md
LTC2311_CAPTURE -- requirements
Module: ltc2311_capture

Interface
REQ-001 Parameter DATA_WIDTH, 16, ADC word width and FIFO write_data width.
REQ-002 Parameter SCK_HALF_PERIOD, 2, clock cycles per SCK half-period (>=1).
REQ-003 Parameter CNV_HIGH_CYCLES, 4, clock cycles adc_cnv is held high.
REQ-004 Parameter CONV_WAIT_CYCLES, 45, clock cycles from adc_cnv falling to first SCK.
REQ-005 Parameter SAMPLE_PERIOD_CYCLES, 128, clock cycles between conversion starts.
REQ-006 clock  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  level; high permits new conversions.
REQ-009 adc_sdo  input  1  ADC serial data, MSB first.
REQ-010 adc_cnv  output  1  ADC conversion start, registered.
REQ-011 adc_sck  output  1  ADC serial clock, idles low, registered.
REQ-012 write_data  output  DATA_WIDTH  captured sample for downstream FIFO.
REQ-013 write_increment  output  1  one-cycle FIFO push strobe.
REQ-014 full  input  1  downstream FIFO full flag.
REQ-015 overrun_count  output  16  samples dropped because full was high.
REQ-016 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, CONVERT, WAIT_CONV, SHIFT, PUSH.
REQ-018 Period counter SHALL count 0..SAMPLE_PERIOD_CYCLES-1 and wrap while enable is high; it SHALL be held at 0 while enable is low.
REQ-019 IDLE->CONVERT SHALL occur on the edge where enable=1 and period counter=0; adc_cnv rises on that same edge.
REQ-020 CONVERT SHALL last exactly CNV_HIGH_CYCLES cycles with adc_cnv=1, then go to WAIT_CONV with adc_cnv=0.
REQ-021 WAIT_CONV SHALL last exactly CONV_WAIT_CYCLES cycles, then go to SHIFT.
REQ-022 SHIFT SHALL produce exactly DATA_WIDTH SCK periods of 2*SCK_HALF_PERIOD cycles each, low half first.
REQ-023 adc_sdo SHALL be sampled on the edge that drives adc_sck high and shifted into a DATA_WIDTH register MSB first.
REQ-024 After the last SCK high half completes, adc_sck SHALL return low and the FSM SHALL enter PUSH.
REQ-025 PUSH SHALL last one cycle: if full=0, write_increment=1 with write_data = captured word; if full=1, write_increment stays 0 and overrun_count increments.
REQ-026 overrun_count SHALL saturate at 16'hFFFF.
REQ-027 write_data SHALL hold its last pushed value between pushes.
REQ-028 PUSH SHALL always return to IDLE.
REQ-029 enable deasserted mid-frame SHALL NOT abort the frame; the frame completes, including PUSH, and no new frame starts.
REQ-030 Frame length CNV_HIGH_CYCLES+CONV_WAIT_CYCLES+2*SCK_HALF_PERIOD*DATA_WIDTH+1 SHALL be <= SAMPLE_PERIOD_CYCLES, checked by an elaboration-time assertion.
REQ-031 full SHALL be evaluated only in PUSH; full during other states has no effect.

Reset
REQ-032 reset SHALL force state IDLE on the next edge, overriding any in-progress frame.
REQ-033 Reset values SHALL be: adc_cnv=0, adc_sck=0, write_increment=0, write_data=0, overrun_count=0, busy=0, period counter=0, shift register=0.
REQ-034 No push SHALL be issued for a frame interrupted by reset.

Structure
REQ-035 Package ltc2311_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-036 Sub-module ltc2311_sck_divider SHALL generate adc_sck, the sample strobe, and the last-bit indication from SCK_HALF_PERIOD.
REQ-037 write_data, write_increment and full SHALL connect directly to the synchronous FIFO write side.

Verification
REQ-038 Default parameters; ADC model returns 16'hA5C3; enable=1 after reset -> adc_cnv high 4 cycles, 45 idle cycles, 16 SCK pulses, one write_increment with write_data=16'hA5C3 at cycle 114 after frame start.
REQ-039 Continuous enable for 3 periods, model returns 16'h0001, 16'h8000, 16'hFFFF -> exactly 3 pushes spaced 128 cycles apart, values in order.
REQ-040 full=1 held through PUSH -> write_increment stays 0 and overrun_count=1; full=1 during SHIFT only -> normal push.
REQ-041 enable dropped during SHIFT -> the frame completes and pushes, then busy=0 and no adc_cnv rise for 300 cycles.
REQ-042 reset asserted mid-SHIFT -> next edge adc_sck=0, busy=0, and no write_increment for that frame.
REQ-043 Force overrun_count to 16'hFFFE with full=1 for 3 frames -> count reads 16'hFFFF and holds.
